adc_acq_seq: RTL
================

Name: adc_acq_seq

Overview:
Parametrised multi-channel acquisition sequencer for AD7643-class serial ADCs. It replaces the single-channel, hard-coded conversion loop with a programmable frame engine. Each frame drives CNVST and CS, waits for BUSY, shifts DATA_W bits from every channel in parallel, and writes one word per channel to the sample memory that the FT600 readout drains. It supports one-shot and continuous (ring) modes and a programmable frame period.

Parameters:
NCH, 2, number of ADC channels sharing CNVST/CS/SCLK
DATA_W, 18, ADC result width
ADDR_W, 14, sample memory address width (depth 2^ADDR_W words)
CNV_LO, 4, CNVST low pulse width in CLK cycles
SCLK_DIV, 2, CLK cycles per SCLK half-period (>=1)
BUSY_TO, 255, max CLK cycles waiting for BUSY low before timeout

Ports:
CLK  in  1  system clock
RSTN  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse, begin acquisition
STOP  in  1  one-cycle pulse, stop after current frame
CONT  in  1  1=ring mode, 0=one-shot; sampled at START
NFRAMES  in  ADDR_W  frames to take in one-shot mode (0 = none, DONE at once)
PERIOD  in  16  CLK cycles from CNVST fall to next CNVST fall (min enforced = frame length)
ADCS  out  1  ADC chip select, active low
ADCNVST  out  1  convert start, active low
ADSCLK  out  1  serial clock to all ADCs
ADSDOUT  in  NCH  serial data, channel i on bit i
ADBUSY  in  NCH  conversion busy, channel i on bit i
MEM_WE  out  1  sample memory write strobe
MEM_ADDR  out  ADDR_W  write address
MEM_WDATA  out  DATA_W  write data
RUN  out  1  high while not IDLE
DONE  out  1  one-cycle pulse on one-shot completion or STOP completion
WRAP  out  1  sticky: ring address wrapped; cleared by START
TMO  out  1  sticky: BUSY timeout seen; cleared by START
FRAME_CNT  out  ADDR_W  frames completed since START

Behaviour:
- Reset, async on RSTN low: ADCS=1, ADCNVST=1, ADSCLK=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, RUN=0, DONE=0, WRAP=0, TMO=0, FRAME_CNT=0; FSM=IDLE. Reset mid-frame abandons the frame with no partial write.
- All inputs are synchronous to CLK. ADSDOUT and ADBUSY are double-registered internally. The 2-cycle input latency is included in the bit-sample timing.
- IDLE: on START, latch CONT and NFRAMES, clear WRAP, TMO, FRAME_CNT, and MEM_ADDR, then go to CNV. If NFRAMES=0 with CONT=0, pulse DONE and stay in IDLE. START outside IDLE is ignored.
- CNV: ADCS=0, ADCNVST=0 for CNV_LO cycles, then ADCNVST=1. The period counter starts at CNVST fall. Then go to WAITB.
- WAITB: wait until the synchronised ADBUSY is all zero. If the count reaches BUSY_TO, set TMO and proceed anyway. Then go to SHIFT.
- SHIFT: generate DATA_W SCLK periods. SCLK is low SCLK_DIV cycles, then high SCLK_DIV cycles. Data is MSB first. Each channel's shift register captures its synchronised SDOUT bit on the last CLK cycle of each high half. SCLK returns to 0 after the last bit. ADCS=1 on exit.
- STORE: NCH consecutive cycles with MEM_WE=1, channel 0 first. MEM_WDATA is the channel result.
  - MEM_ADDR increments after each write, modulo 2^ADDR_W.
  - A 2^ADDR_W-1 -> 0 rollover in ring mode sets WRAP.
  - One-shot writes never exceed address 2^ADDR_W-1. If the next frame does not fit, the run ends.
- After STORE, FRAME_CNT increments, then:
  - one-shot with FRAME_CNT==NFRAMES, or memory full: pulse DONE, go to IDLE;
  - STOP was seen during the frame: pulse DONE, go to IDLE;
  - otherwise go to GAP.
- GAP: wait until the period counter reaches PERIOD-1, then go to CNV. If PERIOD is less than the frame length, go to CNV next cycle with no stall.
- STOP in IDLE is ignored. STOP and START in the same IDLE cycle: START wins. STOP pending is latched until the frame ends.
- Frame length in cycles = CNV_LO + (BUSY wait) + 2*SCLK_DIV*DATA_W + NCH + 1.

Optional Feature:
AVG_EN:
- Defined: adds input AVG_LOG2 [2:0].
  - Each stored frame is the mean of 2^AVG_LOG2 consecutive conversions per channel.
  - Accumulators are DATA_W+7 bits. The result is the accumulated sum >> AVG_LOG2, truncated.
  - STORE, MEM_WE, and FRAME_CNT occur only on the last conversion of each group.
  - PERIOD applies per conversion.
  - STOP ends after the current group completes.
- Undefined: no AVG_LOG2 port; every conversion is stored.

Test Plan:
- NCH=2, CONT=0, NFRAMES=3, ADC model returns ch0=0x2AAAA, ch1=0x15555 -> 6 writes, addr 0..5 alternating 0x2AAAA/0x15555, DONE pulse once, FRAME_CNT=3, RUN low after.
- PERIOD=200 -> CNVST falling edges exactly 200 CLK apart. PERIOD=10 (< frame length) -> back-to-back frames with no gap cycles.
- CONT=1, ADDR_W=4, NCH=2 -> after 8 frames WRAP=1 and the 9th frame writes addr 0,1. STOP mid-SHIFT -> frame completes, DONE, IDLE.
- ADBUSY held high -> TMO=1 after 255 cycles, frame still stored. A subsequent START clears TMO.
- RSTN low during SHIFT -> ADCS=1, ADCNVST=1, ADSCLK=0, MEM_WE=0 immediately. No write after release until START.
- AVG_EN, AVG_LOG2=2, conversions 100,101,102,103 -> single stored value 101 per channel.

Source files
------------

// File: rtl/adc_acq_seq_if.sv
// adc_acq_seq_if
//   Pin/bus bundle between the acquisition sequencer and its surroundings:
//   the shared ADC control pins, the per-channel ADC returns, and the
//   sample-memory write port.
//
//   Signals
//     ADCS       chip select to all ADCs, active low
//     ADCNVST    convert start, active low
//     ADSCLK     serial clock to all ADCs
//     ADSDOUT    [NCH]     serial data, channel i on bit i
//     ADBUSY     [NCH]     conversion busy, channel i on bit i
//     MEM_WE     sample memory write strobe
//     MEM_ADDR   [ADDR_W]  write address
//     MEM_WDATA  [DATA_W]  write data
//
//   Modports
//     master  the sequencer (drives ADC control and memory port)
//     slave   the ADCs/memory side
interface adc_acq_seq_if #(
  parameter int NCH    = 2,
  parameter int DATA_W = 18,
  parameter int ADDR_W = 14
);
  logic              ADCS;
  logic              ADCNVST;
  logic              ADSCLK;
  logic [NCH-1:0]    ADSDOUT;
  logic [NCH-1:0]    ADBUSY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;

  modport master (
    output ADCS, ADCNVST, ADSCLK, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  ADSDOUT, ADBUSY
  );

  modport slave (
    input  ADCS, ADCNVST, ADSCLK, MEM_WE, MEM_ADDR, MEM_WDATA,
    output ADSDOUT, ADBUSY
  );
endinterface

// File: rtl/adc_acq_seq.sv
// adc_acq_seq
//   Multi-channel acquisition sequencer for AD7643-class serial ADCs.
//   Each frame pulses CNVST, waits for BUSY to drop (with timeout), clocks
//   DATA_W bits from all channels in parallel (MSB first) and writes one
//   word per channel into the sample memory. One-shot and ring modes, with
//   a programmable CNVST-to-CNVST period.
//
//   Optional build macro AVG_EN: adds AVG_LOG2 and stores the mean of
//   2^AVG_LOG2 conversions per channel instead of every conversion.
//
//   Ports
//     CLK, RSTN   clock, asynchronous active-low reset
//     START       pulse: begin acquisition (IDLE only)
//     STOP        pulse: stop after the current frame
//     CONT        1 = ring mode, 0 = one-shot (sampled at START)
//     NFRAMES     one-shot frame count (sampled at START)
//     PERIOD      CLK cycles between CNVST falling edges
//     AVG_LOG2    (AVG_EN only) log2 of conversions averaged per frame
//     bus         ADC pins and memory write port (master modport)
//     RUN         high while not IDLE
//     DONE        one-cycle pulse at end of run
//     WRAP, TMO   sticky: ring wrapped / BUSY timeout, cleared by START
//     FRAME_CNT   frames stored since START
module adc_acq_seq #(
  parameter int NCH      = 2,
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 14,
  parameter int CNV_LO   = 4,
  parameter int SCLK_DIV = 2,
  parameter int BUSY_TO  = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              STOP,
  input  logic              CONT,
  input  logic [ADDR_W-1:0] NFRAMES,
  input  logic [15:0]       PERIOD,
`ifdef AVG_EN
  input  logic [2:0]        AVG_LOG2,
`endif
  adc_acq_seq_if.master     bus,
  output logic              RUN,
  output logic              DONE,
  output logic              WRAP,
  output logic              TMO,
  output logic [ADDR_W-1:0] FRAME_CNT
);

  localparam int CMAX0 = (BUSY_TO > CNV_LO - 1) ? BUSY_TO : CNV_LO - 1;
  localparam int CMAX  = (CMAX0 > NCH - 1) ? CMAX0 : NCH - 1;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int HW    = $clog2(2 * SCLK_DIV);
  localparam int BW    = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_WAITB,
    S_SHIFT,
    S_STORE,
    S_GAP
  } state_t;

  state_t            state, state_nx;

  logic [CW-1:0]     cnt;        // CNV width / BUSY wait / STORE channel
  logic [HW-1:0]     hcnt;       // position within one SCLK period
  logic [BW-1:0]     bcnt;       // bit index within the word
  logic [15:0]       pcnt;       // cycles since CNVST fall, saturating
  logic [ADDR_W-1:0] mem_addr;
  logic              cont_l;
  logic [ADDR_W-1:0] nfr_l;
  logic              stop_pend;

  logic [NCH-1:0]    sdo_m, sdo_s;
  logic [NCH-1:0]    bsy_m, bsy_s;
  logic [DATA_W-1:0] sr [NCH];

  logic              busy_expire;
  logic              bit_cap;
  logic              shift_last;
  logic              store_last;
  logic              group_last;
  logic              period_ok;
  logic              fits;
  logic              end_run;
  logic [ADDR_W+1:0] room_end;
  logic [ADDR_W-1:0] frame_cnt_nx;
  logic [DATA_W-1:0] wdata;

`ifdef AVG_EN
  localparam int AW = DATA_W + 7;
  logic [2:0]        avg_l;
  logic [6:0]        avg_cnt;
  logic [7:0]        grp_n;
  logic [AW-1:0]     acc [NCH];
  logic [AW-1:0]     sum [NCH];
  logic [DATA_W-1:0] res [NCH];

  assign grp_n      = 8'd1 << avg_l;
  assign group_last = ({1'b0, avg_cnt} == (grp_n - 8'd1));

  // Sum includes the bit captured on this very cycle so the mean is ready
  // without an extra pipeline cycle.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      sum[i] = acc[i] + AW'({sr[i][DATA_W-2:0], sdo_s[i]});
    end
  end
`else
  assign group_last = 1'b1;
`endif

  assign busy_expire  = (cnt == CW'(BUSY_TO));
  assign bit_cap      = (state == S_SHIFT) && (hcnt == HW'(2 * SCLK_DIV - 1));
  assign shift_last   = bit_cap && (bcnt == BW'(DATA_W - 1));
  assign store_last   = (state == S_STORE) && (cnt == CW'(NCH - 1));
  assign period_ok    = ((17'(pcnt) + 17'd1) >= 17'(PERIOD));
  assign frame_cnt_nx = FRAME_CNT + ADDR_W'(1);

  // Next frame fits in one-shot mode if addresses mem_addr+1 .. mem_addr+NCH
  // all stay within the memory.
  assign room_end = {2'b00, mem_addr} + (ADDR_W+2)'(NCH + 1);
  assign fits     = (room_end <= (ADDR_W+2)'(2 ** ADDR_W));
  assign end_run  = store_last &&
                    ((!cont_l && ((frame_cnt_nx == nfr_l) || !fits)) ||
                     stop_pend || STOP);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (START && (CONT || (NFRAMES != '0))) state_nx = S_CNV;
      S_CNV:   if (cnt == CW'(CNV_LO - 1)) state_nx = S_WAITB;
      S_WAITB: if ((bsy_s == '0) || busy_expire) state_nx = S_SHIFT;
      S_SHIFT: if (shift_last) state_nx = group_last ? S_STORE : S_GAP;
      S_STORE: if (store_last) state_nx = end_run ? S_IDLE : S_GAP;
      S_GAP:   if (period_ok) state_nx = S_CNV;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wdata = '0;
    if (state == S_STORE) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cnt == CW'(i)) begin
`ifdef AVG_EN
          wdata = res[i];
`else
          wdata = sr[i];
`endif
        end
      end
    end
  end

  // ADC pins decode straight from state so an asynchronous reset releases
  // them in the same instant.
  assign bus.ADCS      = !((state == S_CNV) || (state == S_WAITB) || (state == S_SHIFT));
  assign bus.ADCNVST   = (state != S_CNV);
  assign bus.ADSCLK    = (state == S_SHIFT) && (hcnt >= HW'(SCLK_DIV));
  assign bus.MEM_WE    = (state == S_STORE);
  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_WDATA = wdata;
  assign RUN           = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      bcnt      <= '0;
      pcnt      <= '0;
      mem_addr  <= '0;
      cont_l    <= 1'b0;
      nfr_l     <= '0;
      stop_pend <= 1'b0;
      sdo_m     <= '0;
      sdo_s     <= '0;
      bsy_m     <= '0;
      bsy_s     <= '0;
      DONE      <= 1'b0;
      WRAP      <= 1'b0;
      TMO       <= 1'b0;
      FRAME_CNT <= '0;
      for (int unsigned i = 0; i < NCH; i++) sr[i] <= '0;
`ifdef AVG_EN
      avg_l   <= '0;
      avg_cnt <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        res[i] <= '0;
      end
`endif
    end else begin
      state <= state_nx;
      DONE  <= 1'b0;
      sdo_m <= bus.ADSDOUT;
      sdo_s <= sdo_m;
      bsy_m <= bus.ADBUSY;
      bsy_s <= bsy_m;

      if (state_nx != state) begin
        cnt <= '0;
      end else if ((state == S_CNV) || (state == S_WAITB) || (state == S_STORE)) begin
        cnt <= cnt + CW'(1);
      end

      if ((state_nx == S_CNV) && (state != S_CNV)) begin
        pcnt <= '0;
      end else if (pcnt != '1) begin
        pcnt <= pcnt + 16'd1;
      end

      if (state != S_SHIFT) begin
        hcnt <= '0;
        bcnt <= '0;
      end else if (bit_cap) begin
        hcnt <= '0;
        bcnt <= bcnt + BW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end

      if (bit_cap) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          sr[i] <= {sr[i][DATA_W-2:0], sdo_s[i]};
        end
      end

      if ((state == S_IDLE) && START) begin
        cont_l    <= CONT;
        nfr_l     <= NFRAMES;
        WRAP      <= 1'b0;
        TMO       <= 1'b0;
        FRAME_CNT <= '0;
        mem_addr  <= '0;
        if (!CONT && (NFRAMES == '0)) DONE <= 1'b1;
      end

      if (state_nx == S_IDLE) begin
        stop_pend <= 1'b0;
      end else if (STOP && (state != S_IDLE)) begin
        stop_pend <= 1'b1;
      end

      if ((state == S_WAITB) && (bsy_s != '0) && busy_expire) TMO <= 1'b1;

      if (state == S_STORE) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        if (cont_l && (mem_addr == '1)) WRAP <= 1'b1;
      end

      if (store_last) begin
        FRAME_CNT <= frame_cnt_nx;
        if (end_run) DONE <= 1'b1;
      end

`ifdef AVG_EN
      if ((state == S_IDLE) && START) begin
        avg_l   <= AVG_LOG2;
        avg_cnt <= '0;
        for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
      end else if (shift_last) begin
        avg_cnt <= group_last ? 7'd0 : avg_cnt + 7'd1;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (group_last) begin
            res[i] <= DATA_W'(sum[i] >> avg_l);
            acc[i] <= '0;
          end else begin
            acc[i] <= sum[i];
          end
        end
      end
`endif
    end
  end

endmodule
